// File: rtl/resampler_pkg.sv
// Shared arithmetic helpers for the resampler datapath: round-half-up, output clamping
// and saturating event counters. Everything works on a wide signed working type.
package resampler_pkg;

   localparam int CALC_W = 64;

   typedef logic signed [CALC_W-1:0] calc_t;
   typedef logic [CALC_W-1:0]        ucalc_t;

   function automatic calc_t out_max(input int w);
      return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
   endfunction

   function automatic calc_t out_min(input int w);
      return -(calc_t'(1) <<< (w - 1));
   endfunction

   // Ties go toward +inf because the half-LSB is added before the arithmetic shift.
   function automatic calc_t round_half_up(input calc_t x, input int shift);
      if (shift == 0) return x;
      return (x + (calc_t'(1) <<< (shift - 1))) >>> shift;
   endfunction

   function automatic logic is_sat(input calc_t x, input int w);
      return (x > out_max(w)) || (x < out_min(w));
   endfunction

   function automatic calc_t sat_clip(input calc_t x, input int w);
      if (x > out_max(w)) return out_max(w);
      if (x < out_min(w)) return out_min(w);
      return x;
   endfunction

   function automatic calc_t round_sat(input calc_t x, input int shift, input int w);
      return sat_clip(round_half_up(x, shift), w);
   endfunction

   // Counter increment that sticks at all-ones of a w-bit counter.
   function automatic ucalc_t sat_inc(input ucalc_t cnt, input int w);
      ucalc_t top;
      top = (ucalc_t'(1) << w) - ucalc_t'(1);
      return (cnt == top) ? cnt : cnt + ucalc_t'(1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered output word.
// count includes the output register, so capacity is DEPTH words in total.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   mem_cnt;
   logic             out_vld;

   logic rd;
   logic out_free;
   logic wr_ok;
   logic pop_mem;
   logic load_din;
   logic push_mem;

   assign rd       = out_vld && rd_en;
   assign out_free = !out_vld || rd;
   assign count    = mem_cnt + (PTR_W+1)'(out_vld);
   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign empty    = !out_vld;
   assign wr_ok    = wr_en && (!full || rd);
   assign pop_mem  = out_free && (mem_cnt != '0);
   // An empty FIFO loads the write straight into the output register (visible next cycle).
   assign load_din = out_free && (mem_cnt == '0) && wr_ok;
   assign push_mem = wr_ok && !load_din;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
         out_vld <= 1'b0;
         dout    <= '0;
      end else begin
         if (push_mem) wr_ptr <= wr_ptr + 1'b1;
         if (pop_mem)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_mem, pop_mem})
            2'b10:   mem_cnt <= mem_cnt + 1'b1;
            2'b01:   mem_cnt <= mem_cnt - 1'b1;
            default: mem_cnt <= mem_cnt;
         endcase
         if (out_free) out_vld <= pop_mem || load_din;
         if (pop_mem)
            dout <= mem[rd_ptr];
         else if (load_din)
            dout <= din;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_mem) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/resampler_out_fmt.sv
// Output formatter: per-channel round and saturate, FIFO buffering toward a
// valid/ready master, with sticky drop flag and saturating event counters.
module resampler_out_fmt
   import resampler_pkg::*;
#(
   parameter int CH_NUM     = 2,
   parameter int IN_WIDTH   = 34,
   parameter int OUT_WIDTH  = 16,
   parameter int SHIFT      = 15,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            tvalid_i,
   input  logic [CH_NUM*IN_WIDTH-1:0]      tdata_i,
   output logic                            m_tvalid_o,
   input  logic                            m_tready_i,
   output logic [CH_NUM*OUT_WIDTH-1:0]     m_tdata_o,
   output logic [$clog2(FIFO_DEPTH):0]     fill_o,
   output logic                            drop_o,
   output logic [CNT_WIDTH-1:0]            sat_cnt_o,
   output logic [CNT_WIDTH-1:0]            drop_cnt_o,
   input  logic                            clear_i
);

   localparam int RND_W = IN_WIDTH + 1;
   localparam int OW    = CH_NUM * OUT_WIDTH;

   logic signed [RND_W-1:0] rnd_c  [CH_NUM];
   logic signed [RND_W-1:0] rnd_p0 [CH_NUM];
   logic                    vld_p0;

   logic [OW-1:0]           dat_c;
   logic [CH_NUM-1:0]       sat_flag_c;
   logic [OW-1:0]           dat_p1;
   logic                    sat_p1;
   logic                    vld_p1;

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      assign rnd_c[g] = RND_W'(round_half_up(calc_t'($signed(tdata_i[g*IN_WIDTH +: IN_WIDTH])), SHIFT));
      assign dat_c[g*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(sat_clip(calc_t'(rnd_p0[g]), OUT_WIDTH));
      assign sat_flag_c[g] = is_sat(calc_t'(rnd_p0[g]), OUT_WIDTH);
   end

   // ---- stage p0: rounding ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) vld_p0 <= 1'b0;
      else       vld_p0 <= tvalid_i;
   end

   always_ff @(posedge clk_i) begin
      if (tvalid_i) rnd_p0 <= rnd_c;
   end

   // ---- stage p1: saturation ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) vld_p1 <= 1'b0;
      else       vld_p1 <= vld_p0;
   end

   always_ff @(posedge clk_i) begin
      if (vld_p0) begin
         dat_p1 <= dat_c;
         sat_p1 <= |sat_flag_c;
      end
   end

   // ---- output FIFO and event accounting ----
   logic fifo_empty;
   logic fifo_full;
   logic rd;
   logic drop_ev;
   logic sat_ev;

   sync_fifo #(
      .WIDTH (OW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .wr_en (vld_p1),
      .din   (dat_p1),
      .rd_en (m_tready_i),
      .dout  (m_tdata_o),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fill_o)
   );

   assign m_tvalid_o = !fifo_empty;
   assign rd         = m_tvalid_o && m_tready_i;
   assign drop_ev    = vld_p1 && fifo_full && !rd;
   // Saturation is counted even for samples that are then dropped.
   assign sat_ev     = vld_p1 && sat_p1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sat_cnt_o  <= '0;
         drop_cnt_o <= '0;
         drop_o     <= 1'b0;
      end else if (clear_i) begin
         sat_cnt_o  <= '0;
         drop_cnt_o <= '0;
         drop_o     <= 1'b0;
      end else begin
         if (sat_ev)
            sat_cnt_o <= CNT_WIDTH'(sat_inc(CALC_W'(sat_cnt_o), CNT_WIDTH));
         if (drop_ev) begin
            drop_cnt_o <= CNT_WIDTH'(sat_inc(CALC_W'(drop_cnt_o), CNT_WIDTH));
            drop_o     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_resampler_out_fmt.sv
// Directed bench for resampler_out_fmt: rounding, saturation, overflow, backpressure,
// full-with-read, clear and mid-burst reset.
module tb_resampler_out_fmt;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        tvalid_i;
   logic [67:0] tdata_i;
   logic        m_tvalid_o;
   logic        m_tready_i;
   logic [31:0] m_tdata_o;
   logic [4:0]  fill_o;
   logic        drop_o;
   logic [15:0] sat_cnt_o;
   logic [15:0] drop_cnt_o;
   logic        clear_i;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   resampler_out_fmt #(
      .CH_NUM(2), .IN_WIDTH(34), .OUT_WIDTH(16), .SHIFT(15), .FIFO_DEPTH(16), .CNT_WIDTH(16)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .tvalid_i   (tvalid_i),
      .tdata_i    (tdata_i),
      .m_tvalid_o (m_tvalid_o),
      .m_tready_i (m_tready_i),
      .m_tdata_o  (m_tdata_o),
      .fill_o     (fill_o),
      .drop_o     (drop_o),
      .sat_cnt_o  (sat_cnt_o),
      .drop_cnt_o (drop_cnt_o),
      .clear_i    (clear_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [67:0] mk(input longint a, input longint b);
      logic [33:0] x, y;
      x = 34'(a);
      y = 34'(b);
      return {y, x};
   endfunction

   function automatic logic [31:0] ex(input int a, input int b);
      logic [15:0] x, y;
      x = 16'(a);
      y = 16'(b);
      return {y, x};
   endfunction

   function automatic logic [67:0] kv(input int k);
      return mk(longint'(k) * 32768, -longint'(k) * 32768);
   endfunction

   task automatic send(input logic [67:0] d);
      tvalid_i = 1'b1;
      tdata_i  = d;
      tick();
      tvalid_i = 1'b0;
   endtask

   task automatic pop(input string tag, input logic [31:0] e);
      chk({tag, "_vld"}, 64'(m_tvalid_o), 64'd1);
      chk(tag, 64'(m_tdata_o), 64'(e));
      m_tready_i = 1'b1;
      tick();
      m_tready_i = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] q[$];
      logic        stall_v;
      logic [31:0] stall_d;
      int          sent;

      rst_i = 1'b1; tvalid_i = 1'b0; tdata_i = '0; m_tready_i = 1'b0; clear_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;

      chk("rst_tvalid", 64'(m_tvalid_o), 64'd0);
      chk("rst_tdata",  64'(m_tdata_o),  64'd0);
      chk("rst_fill",   64'(fill_o),     64'd0);
      chk("rst_drop",   64'(drop_o),     64'd0);
      chk("rst_satcnt", 64'(sat_cnt_o),  64'd0);
      chk("rst_dropcnt",64'(drop_cnt_o), 64'd0);

      // Rounding and latency
      send(mk(32768, 0));
      chk("lat1", 64'(m_tvalid_o), 64'd0);
      tick();
      chk("lat2", 64'(m_tvalid_o), 64'd0);
      tick();
      chk("lat3", 64'(m_tvalid_o), 64'd1);
      send(mk(49151, 0));
      send(mk(49152, 0));
      send(mk(-16384, 0));
      send(mk(-16385, 0));
      repeat (3) tick();
      chk("rnd_fill", 64'(fill_o), 64'd5);
      pop("rnd_32768",  ex(1, 0));
      pop("rnd_49151",  ex(1, 0));
      pop("rnd_49152",  ex(2, 0));
      pop("rnd_m16384", ex(0, 0));
      pop("rnd_m16385", ex(-1, 0));
      chk("rnd_empty",  64'(m_tvalid_o), 64'd0);
      chk("rnd_satcnt", 64'(sat_cnt_o),  64'd0);

      // Saturation
      send(mk(longint'(1) << 31, -(longint'(1) << 31)));
      repeat (3) tick();
      chk("sat_cnt1", 64'(sat_cnt_o), 64'd1);
      send(mk(longint'(32767) * 32768, -longint'(32768) * 32768));
      repeat (3) tick();
      chk("sat_cnt_edge", 64'(sat_cnt_o), 64'd1);
      send(mk(longint'(32767) * 32768 + 16384, 0));
      repeat (3) tick();
      chk("sat_cnt_round_up", 64'(sat_cnt_o), 64'd2);
      pop("sat_big",   ex(32767, -32768));
      pop("sat_edge",  ex(32767, -32768));
      pop("sat_round", ex(32767, 0));

      // Overflow with output stalled
      for (int k = 1; k <= 20; k++) send(kv(k));
      repeat (3) tick();
      chk("ovf_fill",    64'(fill_o),     64'd16);
      chk("ovf_dropcnt", 64'(drop_cnt_o), 64'd4);
      chk("ovf_drop",    64'(drop_o),     64'd1);
      for (int k = 1; k <= 16; k++) pop($sformatf("ovf_out%0d", k), ex(k, -k));
      chk("ovf_empty", 64'(m_tvalid_o), 64'd0);
      chk("ovf_fill0", 64'(fill_o),     64'd0);

      // Clear
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      chk("clr_dropcnt", 64'(drop_cnt_o), 64'd0);
      chk("clr_drop",    64'(drop_o),     64'd0);
      chk("clr_satcnt",  64'(sat_cnt_o),  64'd0);

      // Backpressure with random ready
      sent = 0; stall_v = 1'b0; stall_d = '0;
      for (int cyc = 0; cyc < 2000 && (sent < 40 || q.size() != 0); cyc++) begin
         if (stall_v) chk("bp_stall", {31'd0, m_tvalid_o, m_tdata_o}, {31'd0, 1'b1, stall_d});
         tvalid_i = (sent < 40) && (cyc % 3 == 0);
         if (tvalid_i) begin
            sent++;
            tdata_i = mk(longint'(sent) * 32768 + 100, -longint'(sent) * 32768);
            q.push_back(ex(sent, -sent));
         end
         m_tready_i = ($urandom_range(3) != 0);
         if (m_tvalid_o && m_tready_i) begin
            chk("bp_data", 64'(m_tdata_o), 64'((q.size() != 0) ? q[0] : 32'hdeadbeef));
            if (q.size() != 0) void'(q.pop_front());
         end
         stall_v = m_tvalid_o && !m_tready_i;
         stall_d = m_tdata_o;
         tick();
      end
      tvalid_i = 1'b0; m_tready_i = 1'b0;
      chk("bp_drained", 64'(q.size()),   64'd0);
      chk("bp_dropcnt", 64'(drop_cnt_o), 64'd0);
      chk("bp_empty",   64'(m_tvalid_o), 64'd0);

      // Full FIFO with simultaneous read and write
      for (int k = 1; k <= 16; k++) send(kv(k));
      repeat (3) tick();
      chk("fr_fill_pre", 64'(fill_o), 64'd16);
      send(kv(17));
      tick();
      m_tready_i = 1'b1;
      tick();
      m_tready_i = 1'b0;
      chk("fr_fill",    64'(fill_o),     64'd16);
      chk("fr_dropcnt", 64'(drop_cnt_o), 64'd0);
      chk("fr_drop",    64'(drop_o),     64'd0);
      for (int k = 2; k <= 17; k++) pop($sformatf("fr_out%0d", k), ex(k, -k));
      chk("fr_empty", 64'(m_tvalid_o), 64'd0);

      // Clear coincident with a drop, then an uncleared drop
      for (int k = 1; k <= 16; k++) send(kv(k));
      repeat (3) tick();
      send(kv(30));
      tick();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      chk("cd_dropcnt", 64'(drop_cnt_o), 64'd0);
      chk("cd_drop",    64'(drop_o),     64'd0);
      send(kv(31));
      repeat (2) tick();
      chk("d_dropcnt", 64'(drop_cnt_o), 64'd1);
      chk("d_drop",    64'(drop_o),     64'd1);

      // Mid-burst reset at fill 9 with a sample in flight
      for (int k = 1; k <= 7; k++) pop($sformatf("pre_rst%0d", k), ex(k, -k));
      chk("pre_rst_fill", 64'(fill_o), 64'd9);
      send(kv(50));
      rst_i = 1'b1;
      #1;
      chk("arst_tvalid", 64'(m_tvalid_o), 64'd0);
      chk("arst_fill",   64'(fill_o),     64'd0);
      chk("arst_dropcnt",64'(drop_cnt_o), 64'd0);
      tick();
      rst_i = 1'b0;
      repeat (3) tick();
      chk("post_rst_tvalid", 64'(m_tvalid_o), 64'd0);
      chk("post_rst_fill",   64'(fill_o),     64'd0);
      send(kv(5));
      repeat (2) tick();
      chk("post_rst_fill1", 64'(fill_o), 64'd1);
      pop("post_rst_out", ex(5, -5));
      chk("post_rst_empty", 64'(m_tvalid_o), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/resampler_out_fmt.md
Name: resampler_out_fmt

Overview:
Output formatting stage directly downstream of the resampler. Takes full-precision multichannel FIR/decimator samples (valid-only, no backpressure), rounds and saturates each channel to OUT_WIDTH, and buffers the results in a FIFO. The FIFO drives an AXI-Stream-style valid/ready master toward the DAC/DMA path. Drops on FIFO overflow and saturation events are counted for software visibility.

Parameters:
CH_NUM, 2, number of parallel channels (I/Q)
IN_WIDTH, 34, signed input width per channel (DATA_WIDTH+COEF_WIDTH upstream)
OUT_WIDTH, 16, signed output width per channel; must be < IN_WIDTH-SHIFT+1
SHIFT, 15, LSBs discarded by rounding; 0 means no rounding
FIFO_DEPTH, 16, output FIFO entries; power of two, >= 4
CNT_WIDTH, 16, width of the event counters

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
tvalid_i  in  1  input sample valid (no ready; sample lost if not accepted)
tdata_i  in  CH_NUM*IN_WIDTH  signed per-channel input, ch0 in LSBs
m_tvalid_o  out  1  output valid
m_tready_i  in  1  output ready
m_tdata_o  out  CH_NUM*OUT_WIDTH  signed per-channel output, ch0 in LSBs
fill_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
drop_o  out  1  sticky: at least one sample dropped since last clear
sat_cnt_o  out  CNT_WIDTH  samples with >=1 saturated channel
drop_cnt_o  out  CNT_WIDTH  samples dropped at full FIFO
clear_i  in  1  synchronous clear of drop_o and both counters

Behaviour:
- Reset (async assert, sync-released logic): pipeline valids 0, FIFO empty, m_tvalid_o=0, m_tdata_o=0, fill_o=0, drop_o=0, counters 0. Reset mid-operation discards all in-flight and buffered samples.
- Stage 1 (round): per channel, sign-extend to IN_WIDTH+1, add 2^(SHIFT-1) (skip if SHIFT=0), arithmetic shift right by SHIFT. Round-half-up (toward +inf at ties).
- Stage 2 (saturate): if value > 2^(OUT_WIDTH-1)-1 clamp to max; if < -2^(OUT_WIDTH-1) clamp to min. Per-sample sat flag = OR over channels.
- Latency: tvalid_i at cycle N -> FIFO write at N+2 -> m_tvalid_o at N+3 if FIFO was empty (registered-output FIFO, first-word fall-through).
- Write accepted if FIFO not full, or if full and a read occurs the same cycle. Otherwise the sample is dropped: drop_cnt_o++, drop_o=1.
- sat_cnt_o increments on every stage-2 valid sample with sat flag set, including dropped ones.
- Counters saturate at all-ones; no wrap.
- clear_i: counters/drop_o zero next cycle. If an event coincides with clear_i, clear wins and the event is not counted.
- Output handshake: transfer when m_tvalid_o && m_tready_i. m_tdata_o is stable while m_tvalid_o=1 and m_tready_i=0. m_tvalid_o never drops without a transfer.
- Simultaneous read/write on empty FIFO: the written word becomes visible the next cycle; no bypass.
- fill_o counts stored words including the output register; range 0..FIFO_DEPTH.

Decomposition:
- resampler_pkg: round_sat function (in width, shift, out width), MAX/MIN constants per OUT_WIDTH, and a counter-saturating increment helper. The package is shared with resampler.
- Sub-module sync_fifo (single clock, parameterised width/depth, FWFT, full/empty/count). Top level contains the round/sat pipeline, drop logic and counters.

Test Plan:
- Rounding, defaults: ch0 inputs 32768, 49151, 49152, -16384, -16385 -> outputs 1, 1, 2, 0, -1; first m_tvalid_o 3 cycles after tvalid_i; sat_cnt_o=0.
- Saturation: ch0=2^31, ch1=-2^31 -> ch0=32767, ch1=-32768, sat_cnt_o=1. Then ch0=32767*32768 -> 32767, no sat, sat_cnt_o still 1.
- Overflow: m_tready_i=0, 20 back-to-back samples -> fill_o=16, drop_cnt_o=4, drop_o=1. Then m_tready_i=1 -> first 16 samples out in order, none duplicated.
- Backpressure: random m_tready_i with continuous tvalid_i below drain rate -> output sequence equals reference model; data stable while stalled; drop_cnt_o=0.
- Full with simultaneous read: FIFO full, m_tready_i=1 and tvalid_i=1 same cycle -> write accepted, fill_o stays 16, no drop.
- Clear/reset: clear_i coincident with a drop -> drop_cnt_o=0, drop_o=0. Assert rst_i mid-burst with fill_o=9 -> m_tvalid_o=0 and fill_o=0 immediately; the next sample after release emerges correctly.
